// File: rtl/hdlc_pkg.sv
// Shared constants, FSM state type and flag helper for the bit-serial HDLC framer.
package hdlc_pkg;

    localparam logic [7:0]  HDLC_FLAG    = 8'h7E;
    localparam logic [15:0] CRC_INIT     = 16'hFFFF;
    localparam logic [15:0] CRC_POLY_REV = 16'h8408;
    localparam int          STUFF_RUN    = 5;

    typedef enum logic [2:0] {
        IDLE,
        OPEN,
        DATA,
        FCS,
        CLOSE
    } hdlc_state_e;

    // Flags go out LSB first, so bit index 0 is the first bit on the line.
    function automatic logic flag_bit(input logic [2:0] idx);
        return HDLC_FLAG[idx];
    endfunction

endpackage

// File: rtl/hdlc_framer_crc.sv
// Serial CRC-16/X.25 (reflected 0x8408), one payload bit per enabled cycle.
module crc16_x25_serial
    import hdlc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic        en,
    input  logic        bit_in,
    output logic [15:0] crc_out
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;
    logic        fb;

    always_comb begin
        fb    = crc_q[0] ^ bit_in;
        crc_d = crc_q;
        if (init) begin
            crc_d = CRC_INIT;
        end else if (en) begin
            crc_d = (crc_q >> 1) ^ (fb ? CRC_POLY_REV : 16'h0000);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q <= CRC_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_out = crc_q;

endmodule

// File: rtl/hdlc_framer.sv
// HDLC framer: wraps each tlast-delimited 1-bit AXI-Stream block in flags,
// zero-bit stuffing and an optional CRC-16/X.25 FCS.
//
// state | meaning
// IDLE  | output empty; first flag bit is emitted as soon as a payload bit is offered
// OPEN  | remaining opening flag bits
// DATA  | payload bits (plus stuffed zeros)
// FCS   | ~crc LSB first, 16 bits (plus stuffed zeros)
// CLOSE | closing flag, tlast on its final bit
module hdlc_framer
    import hdlc_pkg::*;
#(
    parameter bit FCS_EN     = 1'b1,
    parameter int OPEN_FLAGS = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic s_axis_tdata,
    input  logic s_axis_tvalid,
    output logic s_axis_tready,
    input  logic s_axis_tlast,
    output logic m_axis_tdata,
    output logic m_axis_tvalid,
    input  logic m_axis_tready,
    output logic m_axis_tlast
);

    // Bit counters hold "bits left after this one"; the first opening flag bit
    // is already sent from IDLE, hence the -2.
    localparam logic [4:0] OPEN_LAST  = 5'(OPEN_FLAGS * 8 - 2);
    localparam logic [4:0] FCS_LAST   = 5'd15;
    localparam logic [4:0] CLOSE_LAST = 5'd7;

    hdlc_state_e state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [2:0]  ones_q, ones_d;
    logic        m_tdata_q, m_tdata_d;
    logic        m_tvalid_q, m_tvalid_d;
    logic        m_tlast_q, m_tlast_d;

    logic        load;
    logic        stuff_pend;
    logic        s_ready;
    logic        crc_init;
    logic        crc_en;
    logic [15:0] crc;
    logic [15:0] fcs_val;
    logic [3:0]  fcs_idx;
    logic [2:0]  flag_idx;

    assign load       = m_axis_tready | ~m_tvalid_q;
    assign stuff_pend = (ones_q == 3'(STUFF_RUN));
    assign s_ready    = (state_q == DATA) && load && !stuff_pend;
    assign fcs_val    = ~crc;
    assign fcs_idx    = ~cnt_q[3:0];
    assign flag_idx   = ~cnt_q[2:0];

    crc16_x25_serial u_crc (
        .clk     (clk),
        .rst     (rst),
        .init    (crc_init),
        .en      (crc_en),
        .bit_in  (s_axis_tdata),
        .crc_out (crc)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ones_d     = ones_q;
        m_tdata_d  = m_tdata_q;
        m_tvalid_d = m_tvalid_q;
        m_tlast_d  = m_tlast_q;
        crc_init   = 1'b0;
        crc_en     = 1'b0;

        if (load) begin
            m_tvalid_d = 1'b0;
            m_tdata_d  = 1'b0;
            m_tlast_d  = 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (s_axis_tvalid) begin
                        m_tvalid_d = 1'b1;
                        m_tdata_d  = flag_bit(3'd0);
                        cnt_d      = OPEN_LAST;
                        ones_d     = 3'd0;
                        crc_init   = 1'b1;
                        state_d    = OPEN;
                    end
                end
                OPEN: begin
                    m_tvalid_d = 1'b1;
                    m_tdata_d  = flag_bit(flag_idx);
                    ones_d     = 3'd0;
                    if (cnt_q == 5'd0) begin
                        state_d = DATA;
                    end else begin
                        cnt_d = cnt_q - 5'd1;
                    end
                end
                DATA: begin
                    if (stuff_pend) begin
                        m_tvalid_d = 1'b1;
                        ones_d     = 3'd0;
                    end else if (s_axis_tvalid) begin
                        m_tvalid_d = 1'b1;
                        m_tdata_d  = s_axis_tdata;
                        crc_en     = 1'b1;
                        ones_d     = s_axis_tdata ? ones_q + 3'd1 : 3'd0;
                        if (s_axis_tlast) begin
                            state_d = FCS_EN ? FCS : CLOSE;
                            cnt_d   = FCS_EN ? FCS_LAST : CLOSE_LAST;
                        end
                    end
                end
                FCS: begin
                    m_tvalid_d = 1'b1;
                    if (stuff_pend) begin
                        ones_d = 3'd0;
                    end else begin
                        m_tdata_d = fcs_val[fcs_idx];
                        ones_d    = fcs_val[fcs_idx] ? ones_q + 3'd1 : 3'd0;
                        if (cnt_q == 5'd0) begin
                            state_d = CLOSE;
                            cnt_d   = CLOSE_LAST;
                        end else begin
                            cnt_d = cnt_q - 5'd1;
                        end
                    end
                end
                CLOSE: begin
                    m_tvalid_d = 1'b1;
                    ones_d     = 3'd0;
                    // A stuff left over from the last data/FCS bit goes out before the flag.
                    if (!stuff_pend) begin
                        m_tdata_d = flag_bit(flag_idx);
                        m_tlast_d = (cnt_q == 5'd0);
                        if (cnt_q == 5'd0) begin
                            state_d = IDLE;
                        end else begin
                            cnt_d = cnt_q - 5'd1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 5'd0;
            ones_q     <= 3'd0;
            m_tdata_q  <= 1'b0;
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ones_q     <= ones_d;
            m_tdata_q  <= m_tdata_d;
            m_tvalid_q <= m_tvalid_d;
            m_tlast_q  <= m_tlast_d;
        end
    end

    assign s_axis_tready = s_ready;
    assign m_axis_tdata  = m_tdata_q;
    assign m_axis_tvalid = m_tvalid_q;
    assign m_axis_tlast  = m_tlast_q;

endmodule

// File: tb/tb_hdlc_framer.sv
// Self-checking bench for hdlc_framer: fixed vectors, reset corner case and a
// randomized run against a frame-level reference model.
module tb_hdlc_framer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [1:0] s_tdata, s_tvalid, s_tlast, m_tready;
    logic [1:0] s_tready, m_tdata, m_tvalid, m_tlast;
    bit   [1:0] rmode;

    int errors = 0;
    int checks = 0;

    hdlc_framer #(.FCS_EN(1'b0), .OPEN_FLAGS(1)) dut0 (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata[0]), .s_axis_tvalid(s_tvalid[0]),
        .s_axis_tready(s_tready[0]), .s_axis_tlast(s_tlast[0]),
        .m_axis_tdata(m_tdata[0]), .m_axis_tvalid(m_tvalid[0]),
        .m_axis_tready(m_tready[0]), .m_axis_tlast(m_tlast[0])
    );

    hdlc_framer #(.FCS_EN(1'b1), .OPEN_FLAGS(2)) dut1 (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata[1]), .s_axis_tvalid(s_tvalid[1]),
        .s_axis_tready(s_tready[1]), .s_axis_tlast(s_tlast[1]),
        .m_axis_tdata(m_tdata[1]), .m_axis_tvalid(m_tvalid[1]),
        .m_axis_tready(m_tready[1]), .m_axis_tlast(m_tlast[1])
    );

    typedef struct {
        int           sel;
        int           plen;
        logic [79:0]  pay;
        int           rm;
        int           mlen;
        logic [127:0] mid;
        int           stall;
    } vec_t;

    bit         pay_q[$];
    logic [1:0] exp0[$], exp1[$], got0[$], got1[$];
    bit   [1:0] hold;
    logic [1:0] hd, hl;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic push_exp(input int sel, input logic d, input logic l);
        if (sel == 0) exp0.push_back({l, d});
        else          exp1.push_back({l, d});
    endtask

    task automatic push_flag(input int sel, input bit last);
        logic [7:0] fl;
        fl = 8'h7E;
        for (int i = 0; i < 8; i++) push_exp(sel, fl[i], last && (i == 7));
    endtask

    task automatic build_fixed(input int sel, input int nopen, input logic [127:0] mid, input int mlen);
        for (int f = 0; f < nopen; f++) push_flag(sel, 1'b0);
        for (int i = 0; i < mlen; i++) push_exp(sel, mid[i], 1'b0);
        push_flag(sel, 1'b1);
    endtask

    // Frame-level reference: flags, payload+FCS run through a stuffer, closing flag.
    task automatic model_frame(input int sel, input bit fcs_en, input int nopen);
        bit          body[$];
        logic [15:0] crc;
        logic        fb;
        int          ones;
        crc  = 16'hFFFF;
        ones = 0;
        for (int f = 0; f < nopen; f++) push_flag(sel, 1'b0);
        foreach (pay_q[k]) begin
            fb  = crc[0] ^ pay_q[k];
            crc = (crc >> 1) ^ (fb ? 16'h8408 : 16'h0000);
            body.push_back(pay_q[k]);
        end
        if (fcs_en) for (int i = 0; i < 16; i++) body.push_back(~crc[i]);
        foreach (body[k]) begin
            push_exp(sel, body[k], 1'b0);
            ones = body[k] ? ones + 1 : 0;
            if (ones == 5) begin
                push_exp(sel, 1'b0, 1'b0);
                ones = 0;
            end
        end
        push_flag(sel, 1'b1);
    endtask

    task automatic send(input int sel, input int n, input bit do_last, input bit gaps,
                        input bit chk_lat, output int stalls);
        int t;
        stalls = 0;
        @(posedge clk); #1;
        for (int k = 0; k < n; k++) begin
            if (gaps && ($urandom % 4 == 0)) begin
                s_tvalid[sel] = 1'b0;
                repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
            end
            s_tdata[sel]  = pay_q[k];
            s_tlast[sel]  = do_last && (k == n - 1);
            s_tvalid[sel] = 1'b1;
            if (k == 0 && chk_lat) begin
                @(posedge clk); #1;
                check("first_flag_latency", int'({m_tvalid[sel], m_tdata[sel]}), 2);
            end
            t = 0;
            @(negedge clk);
            while (!s_tready[sel] && t < 2000) begin
                if (k > 0) stalls++;
                t++;
                @(negedge clk);
            end
            if (t >= 2000) begin
                check("send_timeout", 0, 1);
                s_tvalid[sel] = 1'b0;
                s_tlast[sel]  = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        s_tvalid[sel] = 1'b0;
        s_tlast[sel]  = 1'b0;
    endtask

    task automatic compare(input int sel, input string name, input bit prefix);
        int t, ne, ng, bad;
        logic [1:0] e, g;
        t   = 0;
        bad = -1;
        ne  = (sel == 0) ? exp0.size() : exp1.size();
        if (!prefix) begin
            while (((sel == 0) ? got0.size() : got1.size()) < ne && t < 5000) begin
                @(negedge clk);
                t++;
            end
            repeat (4) @(negedge clk);
        end
        ng = (sel == 0) ? got0.size() : got1.size();
        if (prefix) check({name, "_len_at_least"}, int'(ng >= ne), 1);
        else        check({name, "_len"}, ng, ne);
        for (int k = 0; k < ne && k < ng; k++) begin
            e = (sel == 0) ? exp0[k] : exp1[k];
            g = (sel == 0) ? got0[k] : got1[k];
            if (g !== e && bad < 0) bad = k;
        end
        check({name, "_first_bad_bit_index"}, bad, -1);
        if (sel == 0) begin exp0.delete(); got0.delete(); end
        else          begin exp1.delete(); got1.delete(); end
    endtask

    initial begin
        m_tready = 2'b11;
        forever begin
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) m_tready[i] = rmode[i] ? 1'($urandom % 2) : 1'b1;
        end
    end

    // Collect accepted line bits; a held word must not change while stalled.
    initial begin
        hold = 2'b00;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (rst) begin
                    hold[i] = 1'b0;
                end else begin
                    if (hold[i])
                        check("stalled_output_stable", int'({m_tvalid[i], m_tdata[i], m_tlast[i]}),
                              int'({1'b1, hd[i], hl[i]}));
                    if (m_tvalid[i] && m_tready[i]) begin
                        if (i == 0) got0.push_back({m_tlast[i], m_tdata[i]});
                        else        got1.push_back({m_tlast[i], m_tdata[i]});
                    end
                    hold[i] = m_tvalid[i] && !m_tready[i];
                    hd[i]   = m_tdata[i];
                    hl[i]   = m_tlast[i];
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs[6];
        int   stalls, len;
        logic [79:0]  p9;
        logic [127:0] mid9;

        p9   = 80'h393837363534333231;
        mid9 = 128'h906E393837363534333231;
        vecs[0] = '{0, 8,  80'h0,  0, 8,  128'h0,   0};
        vecs[1] = '{0, 8,  80'hFF, 0, 9,  128'h1DF, 1};
        vecs[2] = '{1, 72, p9,     0, 88, mid9,     0};
        vecs[3] = '{0, 5,  80'h1F, 0, 6,  128'h1F,  0};
        vecs[4] = '{1, 72, p9,     1, 88, mid9,    -1};
        vecs[5] = '{0, 72, p9,     0, 72, 128'h393837363534333231, 0};

        rst      = 1'b1;
        s_tdata  = 2'b00;
        s_tvalid = 2'b00;
        s_tlast  = 2'b00;
        rmode    = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs_dut0", int'({s_tready[0], m_tvalid[0], m_tdata[0], m_tlast[0]}), 0);
        check("reset_outputs_dut1", int'({s_tready[1], m_tvalid[1], m_tdata[1], m_tlast[1]}), 0);
        rst = 1'b0;

        for (int v = 0; v < 6; v++) begin
            pay_q.delete();
            for (int b = 0; b < vecs[v].plen; b++) pay_q.push_back(vecs[v].pay[b]);
            rmode[vecs[v].sel] = (vecs[v].rm != 0);
            build_fixed(vecs[v].sel, (vecs[v].sel == 1) ? 2 : 1, vecs[v].mid, vecs[v].mlen);
            send(vecs[v].sel, vecs[v].plen, 1'b1, 1'b0, 1'b1, stalls);
            if (vecs[v].stall >= 0) check($sformatf("vec%0d_tready_stall_cycles", v), stalls, vecs[v].stall);
            compare(vecs[v].sel, $sformatf("vec%0d", v), 1'b0);
            rmode = 2'b00;
        end

        for (int sel = 0; sel < 2; sel++) begin
            rmode[sel] = 1'b1;
            for (int f = 0; f < 10; f++) begin
                pay_q.delete();
                len = $urandom_range(1, 40);
                for (int b = 0; b < len; b++) pay_q.push_back($urandom % 4 != 0);
                model_frame(sel, sel == 1, (sel == 1) ? 2 : 1);
                send(sel, len, 1'b1, 1'b1, 1'b0, stalls);
            end
            compare(sel, $sformatf("random_dut%0d", sel), 1'b0);
            rmode[sel] = 1'b0;
        end

        // Frame A completes, frame B is cut by reset mid-payload.
        pay_q.delete();
        for (int b = 0; b < 16; b++) pay_q.push_back($urandom % 2 != 0);
        model_frame(1, 1'b1, 2);
        send(1, 16, 1'b1, 1'b0, 1'b1, stalls);
        pay_q.delete();
        for (int b = 0; b < 30; b++) pay_q.push_back($urandom % 2 != 0);
        send(1, 10, 1'b0, 1'b0, 1'b0, stalls);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("post_rst_outputs_dut1", int'({s_tready[1], m_tvalid[1], m_tdata[1], m_tlast[1]}), 0);
        check("post_rst_outputs_dut0", int'({s_tready[0], m_tvalid[0], m_tdata[0], m_tlast[0]}), 0);
        compare(1, "frame_before_rst", 1'b1);

        pay_q.delete();
        for (int b = 0; b < 72; b++) pay_q.push_back(p9[b]);
        build_fixed(1, 2, mid9, 88);
        send(1, 72, 1'b1, 1'b0, 1'b1, stalls);
        compare(1, "frame_after_rst", 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hdlc_framer.md
Name: hdlc_framer

Overview:
Bit-serial HDLC framer that sits directly downstream of the interleaver on the 1-bit AXI-Stream path. Each interleaved block, delimited by s_axis_tlast, is wrapped as one HDLC frame: an opening flag 0x7E, the payload bits with zero-bit stuffing, an optional CRC-16/X.25 FCS, and a closing flag 0x7E. Output is a 1-bit AXI-Stream toward the modulator/line interface.

Parameters:
FCS_EN, 1, 1 = compute and append the 16-bit FCS before the closing flag; 0 = no FCS.
OPEN_FLAGS, 1, number of 0x7E flags sent before each frame's payload (legal range 1..4).

Ports:
clk  in  1  single system clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
s_axis_tdata  in  1  payload bit from the interleaver.
s_axis_tvalid  in  1  payload bit valid.
s_axis_tready  out  1  framer accepts the payload bit this cycle.
s_axis_tlast  in  1  last payload bit of the block/frame.
m_axis_tdata  out  1  line bit.
m_axis_tvalid  out  1  line bit valid.
m_axis_tready  in  1  downstream accepts the line bit.
m_axis_tlast  out  1  high on the final bit of the closing flag.

Behaviour:
- Reset: when rst=1 at a clock edge, state goes to IDLE and all counters clear; CRC is set to 0xFFFF. Outputs m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0 and s_axis_tready=0. Reset asserted mid-frame abandons the frame with no closing flag.
- Output register: a single m_axis register loads when m_axis_tready=1 or m_axis_tvalid=0. When the register holds data and m_axis_tready=0, tdata and tlast stay stable. Bits are never dropped or duplicated.
- Bit order: flags and FCS bytes are sent LSB first. A flag is therefore the sequence 0,1,1,1,1,1,1,0.
- FSM states:
  - IDLE: m_axis_tvalid=0. Move to OPEN when s_axis_tvalid=1; that payload bit is not consumed yet.
  - OPEN: send OPEN_FLAGS×8 flag bits, then go to DATA.
  - DATA: s_axis_tready = load-enable AND no stuff pending. Each accepted bit goes out on the next load and updates the CRC. After the bit with tlast is accepted, go to FCS if FCS_EN=1, otherwise to CLOSE.
  - FCS: send ~crc[15:0] LSB first, 16 bits, then go to CLOSE.
  - CLOSE: send 8 flag bits with m_axis_tlast on the 8th, then go to IDLE.
- Latency: with no backpressure, the first flag bit is valid 1 cycle after s_axis_tvalid is first seen in IDLE.
- Throughput: back-to-back frames restart with their own opening flags (no shared flag).
- Zero-bit stuffing:
  - A 3-bit ones counter tracks consecutive 1s emitted in DATA and FCS. It clears on any emitted 0 and on every flag.
  - After the 5th consecutive 1, the next output slot is a stuffed 0. During that slot s_axis_tready=0 (DATA) or the FCS bit index holds (FCS).
  - A stuff pending at the DATA→FCS or FCS→CLOSE boundary is emitted before the next field. The ones count carries across the DATA→FCS boundary.
- CRC-16/X.25:
  - Init 0xFFFF, reflected polynomial 0x8408.
  - Per payload bit: fb = crc[0]^bit; crc = (crc>>1) ^ (fb ? 0x8408 : 0).
  - Stuffed bits and flags are excluded from the CRC.
  - CRC re-initialises to 0xFFFF on entry to OPEN.
- s_axis_tlast outside DATA is not possible, because tready=0 there. s_axis_tvalid dropping mid-frame stalls the DATA state with no output bits; idle flags are not inserted.

Decomposition:
- Package hdlc_pkg holds: HDLC_FLAG=8'h7E, CRC_INIT=16'hFFFF, CRC_POLY_REV=16'h8408, STUFF_RUN=5, and the FSM state enum (IDLE, OPEN, DATA, FCS, CLOSE).
- One sub-module: crc16_x25_serial (ports: clk, rst, init, en, bit_in, crc_out), a 1-bit-per-cycle CRC instantiated inside the framer.

Test Plan:
- FCS_EN=0, OPEN_FLAGS=1, frame 0x00 (8 zero bits, tlast on bit 8) → 24 line bits: 01111110, 00000000, 01111110. m_axis_tlast on bit 24 only. First valid 1 cycle after s_axis_tvalid.
- FCS_EN=0, frame 0xFF (8 ones) → 01111110, 11111 0 111, 01111110 (25 bits). s_axis_tready low exactly 1 cycle during the stuff slot.
- FCS_EN=1, payload ASCII "123456789" (72 bits, LSB first per byte) → FCS field 0x6E then 0x90 LSB first: 0111 0110 0000 1001. No stuffing occurs, and the closing flag follows.
- FCS_EN=0, frame of 5 ones ending on tlast → ones, stuffed 0, then closing flag; 22 bits total.
- Repeat the "123456789" frame with m_axis_tready on a pseudo-random 50% pattern → line bit sequence identical to the unstalled run; tdata stable while stalled.
- Two back-to-back frames, with rst asserted for 1 cycle mid-payload of the second → first frame complete. After rst, outputs are 0 and the state is IDLE. The next frame starts with a fresh opening flag and CRC=0xFFFF.
